// File: rtl/median_pkg.sv
// Shared types and default sizes for the median datapath.
package median_pkg;

  localparam int unsigned DATA_WIDTH_DEF = 8;
  localparam int unsigned DATA_SIZE_DEF  = 9;
  localparam int unsigned STRIDE_DEF     = 1;
  localparam int unsigned CNT_WIDTH_DEF  = 16;

  typedef enum logic [1:0] {
    FILL    = 2'd0,
    PRESENT = 2'd1,
    SLIDE   = 2'd2
  } feeder_state_e;

endpackage

// File: rtl/median_shift_window.sv
// Sliding sample window: [0] oldest, [DATA_SIZE-1] newest; clear beats shift.
module median_shift_window
  import median_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int unsigned DATA_SIZE  = DATA_SIZE_DEF
) (
  input  logic                  clk_i,
  input  logic                  rstn_i,
  input  logic                  shift_en_i,
  input  logic                  clear_i,
  input  logic [DATA_WIDTH-1:0] din_i,
  output logic [DATA_WIDTH-1:0] window_o [DATA_SIZE]
);

  logic [DATA_WIDTH-1:0] window_q [DATA_SIZE];
  logic [DATA_WIDTH-1:0] window_d [DATA_SIZE];

  always_comb begin
    window_d = window_q;
    if (clear_i) begin
      window_d = '{default: '0};
    end else if (shift_en_i) begin
      for (int unsigned i = 0; i < DATA_SIZE - 1; i++) begin
        window_d[i] = window_q[i + 1];
      end
      window_d[DATA_SIZE - 1] = din_i;
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      window_q <= '{default: '0};
    end else begin
      window_q <= window_d;
    end
  end

  assign window_o = window_q;

endmodule

// File: rtl/median_window_feeder.sv
// Gathers a serial sample stream into sliding windows and presents one
// window per STRIDE new samples to the median block, holding it until taken.
module median_window_feeder
  import median_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int unsigned DATA_SIZE  = DATA_SIZE_DEF,
  parameter int unsigned STRIDE     = STRIDE_DEF,
  parameter int unsigned CNT_WIDTH  = CNT_WIDTH_DEF
) (
  input  logic                             clk_i,
  input  logic                             rstn_i,
  input  logic                             clear_i,
  input  logic [DATA_WIDTH-1:0]            sample_i,
  input  logic                             sample_valid_i,
  output logic                             sample_ready_o,
  output logic [DATA_WIDTH-1:0]            window_o [DATA_SIZE],
  output logic                             window_valid_o,
  input  logic                             window_ready_i,
  output logic [$clog2(DATA_SIZE+1)-1:0]   fill_count_o,
  output logic [CNT_WIDTH-1:0]             windows_o
);

  localparam int unsigned FILL_W   = $clog2(DATA_SIZE + 1);
  localparam int unsigned STRIDE_W = $clog2(DATA_SIZE + 1);

  feeder_state_e         state_q, state_d;
  logic [FILL_W-1:0]     fill_q, fill_d;
  logic [STRIDE_W-1:0]   stride_q, stride_d;
  logic [CNT_WIDTH-1:0]  windows_q, windows_d;
  logic                  accept_c;
  logic                  shift_en_c;

  // Handshake flags come straight off the state register, so the
  // consumption cycle is always a one-cycle input bubble.
  assign sample_ready_o = (state_q != PRESENT);
  assign window_valid_o = (state_q == PRESENT);
  assign accept_c       = sample_valid_i & sample_ready_o;
  assign shift_en_c     = accept_c & ~clear_i;

  always_comb begin
    state_d   = state_q;
    fill_d    = fill_q;
    stride_d  = stride_q;
    windows_d = windows_q;
    if (clear_i) begin
      state_d  = FILL;
      fill_d   = '0;
      stride_d = '0;
    end else begin
      case (state_q)
        FILL: begin
          if (accept_c) begin
            fill_d = fill_q + FILL_W'(1);
            if (fill_q == FILL_W'(DATA_SIZE - 1)) begin
              state_d = PRESENT;
            end
          end
        end
        PRESENT: begin
          if (window_ready_i) begin
            windows_d = windows_q + CNT_WIDTH'(1);
            stride_d  = '0;
            state_d   = SLIDE;
          end
        end
        SLIDE: begin
          if (accept_c) begin
            stride_d = stride_q + STRIDE_W'(1);
            if (stride_q == STRIDE_W'(STRIDE - 1)) begin
              state_d = PRESENT;
            end
          end
        end
        default: begin
          state_d = FILL;
        end
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q   <= FILL;
      fill_q    <= '0;
      stride_q  <= '0;
      windows_q <= '0;
    end else begin
      state_q   <= state_d;
      fill_q    <= fill_d;
      stride_q  <= stride_d;
      windows_q <= windows_d;
    end
  end

  median_shift_window #(
    .DATA_WIDTH (DATA_WIDTH),
    .DATA_SIZE  (DATA_SIZE)
  ) u_window (
    .clk_i      (clk_i),
    .rstn_i     (rstn_i),
    .shift_en_i (shift_en_c),
    .clear_i    (clear_i),
    .din_i      (sample_i),
    .window_o   (window_o)
  );

  assign fill_count_o = fill_q;
  assign windows_o    = windows_q;

endmodule

// File: tb/tb_median_window_feeder.sv
// Scoreboard bench: two feeders (STRIDE=1/CNT_WIDTH=16 and STRIDE=3/CNT_WIDTH=4)
// share one stimulus stream and are checked against a sample-history model.
module tb_median_window_feeder;

  localparam int DW = 8;
  localparam int DS = 9;
  localparam int HMAX = 8192;
  localparam int S0 = 1, S1 = 3;
  localparam int CW0 = 16, CW1 = 4;

  logic          clk_i = 1'b0;
  logic          rstn_i = 1'b0;
  logic          clear_i = 1'b0;
  logic [DW-1:0] sample_i = '0;
  logic          sample_valid_i = 1'b0;
  logic          window_ready_i = 1'b0;

  logic          rdy0, rdy1, val0, val1;
  logic [DW-1:0] win0 [DS];
  logic [DW-1:0] win1 [DS];
  logic [3:0]    fill0, fill1;
  logic [CW0-1:0] cnt0;
  logic [CW1-1:0] cnt1;

  int total = 0;
  int bad = 0;

  // Model: all samples accepted since the last flush, plus handshake bookkeeping.
  logic [DW-1:0] hist [2][HMAX];
  int n    [2];
  int pend [2];
  int cons [2];
  logic [DS*DW-1:0] exp_q0 [$];
  logic [DS*DW-1:0] exp_q1 [$];

  always #5 clk_i = ~clk_i;

  median_window_feeder #(.DATA_WIDTH(DW), .DATA_SIZE(DS), .STRIDE(S0), .CNT_WIDTH(CW0)) dut0 (
    .clk_i(clk_i), .rstn_i(rstn_i), .clear_i(clear_i), .sample_i(sample_i),
    .sample_valid_i(sample_valid_i), .sample_ready_o(rdy0), .window_o(win0),
    .window_valid_o(val0), .window_ready_i(window_ready_i), .fill_count_o(fill0),
    .windows_o(cnt0));

  median_window_feeder #(.DATA_WIDTH(DW), .DATA_SIZE(DS), .STRIDE(S1), .CNT_WIDTH(CW1)) dut1 (
    .clk_i(clk_i), .rstn_i(rstn_i), .clear_i(clear_i), .sample_i(sample_i),
    .sample_valid_i(sample_valid_i), .sample_ready_o(rdy1), .window_o(win1),
    .window_valid_o(val1), .window_ready_i(window_ready_i), .fill_count_o(fill1),
    .windows_o(cnt1));

  task automatic cmp(input string nm, input int k, input logic [DS*DW-1:0] act,
                     input logic [DS*DW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s inst%0d t=%0t: got %0h want %0h", nm, k, $time, act, exp);
    end
  endtask

  function automatic logic [DS*DW-1:0] dut_win(input int k);
    logic [DS*DW-1:0] w;
    for (int i = 0; i < DS; i++) w[i*DW +: DW] = (k == 0) ? win0[i] : win1[i];
    return w;
  endfunction

  // Expected window = last DS accepted samples, zero-padded when fewer exist.
  function automatic logic [DS*DW-1:0] exp_win(input int k);
    logic [DS*DW-1:0] w;
    int idx;
    w = '0;
    for (int i = 0; i < DS; i++) begin
      idx = n[k] - DS + i;
      if (idx >= 0) w[i*DW +: DW] = hist[k][idx];
    end
    return w;
  endfunction

  function automatic int stride_of(input int k);
    return (k == 0) ? S0 : S1;
  endfunction

  function automatic int cw_of(input int k);
    return (k == 0) ? CW0 : CW1;
  endfunction

  task automatic check_outputs();
    for (int k = 0; k < 2; k++) begin
      cmp("sample_ready", k, (k == 0) ? rdy0 : rdy1, (pend[k] == 0) ? 1 : 0);
      cmp("window_valid", k, (k == 0) ? val0 : val1, (pend[k] != 0) ? 1 : 0);
      cmp("fill_count", k, (k == 0) ? fill0 : fill1, (n[k] >= DS) ? DS : n[k]);
      cmp("windows", k, (k == 0) ? cnt0 : cnt1, cons[k]);
      cmp("window", k, dut_win(k), exp_win(k));
    end
  endtask

  task automatic flush(input int k);
    if (k == 0) exp_q0.delete();
    else exp_q1.delete();
  endtask

  task automatic model_step(input logic clr, input logic vld, input logic [DW-1:0] d,
                            input logic wr);
    for (int k = 0; k < 2; k++) begin
      if (clr) begin
        n[k] = 0;
        pend[k] = 0;
        flush(k);
      end else if (pend[k] != 0) begin
        if (wr) begin
          pend[k] = 0;
          cons[k] = (cons[k] + 1) % (1 << cw_of(k));
        end
      end else if (vld) begin
        hist[k][n[k]] = d;
        n[k]++;
        if (n[k] >= DS && ((n[k] - DS) % stride_of(k)) == 0) begin
          pend[k] = 1;
          if (k == 0) exp_q0.push_back(exp_win(k));
          else exp_q1.push_back(exp_win(k));
        end
      end
    end
  endtask

  // Called at posedge+1: check state, drive next inputs, advance model.
  task automatic drive_cycle(input logic clr, input logic vld, input logic [DW-1:0] d,
                             input logic wr);
    check_outputs();
    clear_i = clr;
    sample_valid_i = vld;
    sample_i = d;
    window_ready_i = wr;
    model_step(clr, vld, d, wr);
    @(posedge clk_i);
    #1;
  endtask

  task automatic do_reset();
    rstn_i = 1'b0;
    clear_i = 1'b0;
    sample_valid_i = 1'b0;
    window_ready_i = 1'b0;
    for (int k = 0; k < 2; k++) begin
      n[k] = 0;
      pend[k] = 0;
      cons[k] = 0;
      flush(k);
    end
    #1;
    check_outputs();
    @(posedge clk_i);
    #1;
    rstn_i = 1'b1;
  endtask

  // Monitor: a handshake is due at the next edge; pop and compare the window.
  always @(negedge clk_i) begin
    if (rstn_i && !clear_i && window_ready_i) begin
      if (val0) begin
        if (exp_q0.size() == 0) cmp("sb_empty", 0, 1, 0);
        else cmp("sb_window", 0, dut_win(0), exp_q0.pop_front());
      end
      if (val1) begin
        if (exp_q1.size() == 0) cmp("sb_empty", 1, 1, 0);
        else cmp("sb_window", 1, dut_win(1), exp_q1.pop_front());
      end
    end
  end

  initial begin
    do_reset();
    // Fill, hold under backpressure, consume, slide by one.
    for (int i = 1; i <= 9; i++) drive_cycle(1'b0, 1'b1, DW'(i), 1'b0);
    repeat (5) drive_cycle(1'b0, 1'b1, 8'd10, 1'b0);
    drive_cycle(1'b0, 1'b1, 8'd10, 1'b1);
    drive_cycle(1'b0, 1'b1, 8'd10, 1'b0);
    repeat (3) drive_cycle(1'b0, 1'b0, 8'd0, 1'b0);
    // Clear and consume in the same cycle: clear wins.
    drive_cycle(1'b1, 1'b1, 8'd11, 1'b1);
    // Partial fill then clear, then a full refill.
    for (int i = 1; i <= 4; i++) drive_cycle(1'b0, 1'b1, DW'(20 + i), 1'b0);
    drive_cycle(1'b1, 1'b0, 8'd0, 1'b0);
    for (int i = 1; i <= 9; i++) drive_cycle(1'b0, 1'b1, DW'(40 + i), 1'b0);
    repeat (2) drive_cycle(1'b0, 1'b0, 8'd0, 1'b0);
    // Async reset while a window is pending.
    do_reset();
    // Streaming with always-ready consumer.
    for (int i = 1; i <= 40; i++) drive_cycle(1'b0, 1'b1, DW'(i), 1'b1);
    // Randomized traffic with occasional clears and resets.
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 399) == 0) begin
        do_reset();
      end else begin
        drive_cycle($urandom_range(0, 149) == 0,
                    $urandom_range(0, 3) != 0,
                    DW'($urandom_range(0, 255)),
                    $urandom_range(0, 4) < 3);
      end
    end
    repeat (4) drive_cycle(1'b0, 1'b0, 8'd0, 1'b1);
    check_outputs();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
